pipeline_run_controller: RTL

//  Sequences the 5-stage MIPS pipeline for the debug unit: IDLE, free-run, single-step, drain on HALT, halted.

---
 rtl/pipeline_run_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
// Run-control sequencer for the 5-stage MIPS pipeline used by the debug unit.
// Walks IDLE -> RUN / STEP -> DRAIN -> HALTED and merges hazard-unit stalls and
// ID-stage redirects into the per-stage register enables. It also counts the
// cycles in which the pipeline advanced.
// Optional feature macro: PIPE_WATCHDOG_EN. When defined, a RUN that reaches
// MAX_CYCLES executed cycles is forced into DRAIN and o_timeout is raised.
module pipeline_run_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_halt_req,
  input  logic             i_halt_detected,
  input  logic             i_hazard_stall,
  input  logic             i_branch_taken,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_pipe_enable,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic             o_step_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [DW-1:0]    drain_cnt;
  logic [DW-1:0]    drain_cnt_next;
  logic             step_done;
  logic             step_done_next;
  logic [CNT_W-1:0] cycle_count;
  logic             halt_go;
  logic             watchdog_hit;
  logic             timeout;

`ifdef PIPE_WATCHDOG_EN
  // The watchdog triggers on the RUN cycle whose execution brings the count up to MAX_CYCLES.
  always_comb begin
    watchdog_hit = 1'b0;
    if (state == ST_RUN && cycle_count >= CNT_W'(MAX_CYCLES - 1))
      watchdog_hit = 1'b1;
  end

  // Sticky timeout flag that only a reset clears.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      timeout <= 1'b0;
    else if (watchdog_hit)
      timeout <= 1'b1;
  end
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign watchdog_hit      = 1'b0;
  assign timeout           = 1'b0;
`endif

  // A stalled HALT decode is not yet real, so only an unstalled one starts the drain.
  assign halt_go = (i_halt_detected & ~i_hazard_stall) | watchdog_hit;

  // Stage enables follow the current state; active cycles merge stall and redirect.
  always_comb begin
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_enable  = 1'b0;
    case (state)
      ST_RUN, ST_STEP: begin
        o_pipe_enable  = 1'b1;
        o_pc_write     = ~i_hazard_stall;
        o_if_id_write  = ~i_hazard_stall;
        o_id_ex_bubble = i_hazard_stall;
        o_if_id_flush  = i_branch_taken & ~i_hazard_stall;
      end
      ST_DRAIN: begin
        o_pipe_enable  = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state selection; a HALT (or watchdog) outranks a halt request or a step's return to IDLE.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    step_done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_run)
          state_next = ST_RUN;
        else if (i_step)
          state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_go) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (i_halt_req) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_go) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else begin
          state_next     = ST_IDLE;
          step_done_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0)
          state_next = ST_HALTED;
        else
          drain_cnt_next = drain_cnt - 1'b1;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Registered control state: FSM, drain countdown and the step-complete pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      step_done <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      step_done <= step_done_next;
    end
  end

  // Executed-cycle counter, saturating so a long run never wraps back to small values.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      cycle_count <= '0;
    else if (o_pipe_enable && cycle_count != '1)
      cycle_count <= cycle_count + 1'b1;
  end

  assign o_state       = state;
  assign o_halted      = (state == ST_HALTED);
  assign o_step_done   = step_done;
  assign o_timeout     = timeout;
  assign o_cycle_count = cycle_count;

endmodule
